sa_demux2_pipe: RTL and testbench
=================================

# sa_demux2_pipe

Two-way valid/ready stream demultiplexer. It is the distribution-side counterpart of the 2:1 select cell in the systolic-array library. Each input beat carries a select bit and is steered to one of two output ports. Each output has a 2-entry buffer, so there is no combinational path from either output's ready to the input ready. In packet mode the select is locked per packet, so a multi-beat transfer never splits across outputs.

## Interface
Parameters:
- WIDTH, 32, data width of input and both outputs.
- PKT_MODE, 1, 1: select sampled on first beat of packet and held until in_last; 0: select honoured per beat.

Ports:
- nvdla_core_clk  input  1  sole clock, rising edge.
- nvdla_core_rstn  input  1  asynchronous, active-low reset.
- in_vld  input  1  input beat valid.
- in_rdy  output  1  input beat accepted when in_vld & in_rdy.
- in_data  input  WIDTH  input payload.
- in_sel  input  1  destination: 0 selects out0, 1 selects out1.
- in_last  input  1  last beat of packet; ignored when PKT_MODE=0.
- out0_vld / out1_vld  output  1  output beat valid.
- out0_rdy / out1_rdy  input  1  downstream ready.
- out0_data / out1_data  output  WIDTH  output payload (head of buffer).
- out0_last / out1_last  output  1  forwarded in_last.
- lock_state  output  2  current FSM state, for debug.

## Operation
- Effective select `esel`:
  - PKT_MODE=0: esel = in_sel.
  - PKT_MODE=1, state IDLE: esel = in_sel.
  - PKT_MODE=1, state LOCK0: esel = 0, in_sel ignored.
  - PKT_MODE=1, state LOCK1: esel = 1, in_sel ignored.
- FSM encoding: IDLE=2'b00, LOCK0=2'b01, LOCK1=2'b10.
  - IDLE → LOCKn on an accepted beat with in_last=0 and esel=n.
  - LOCKn → IDLE on an accepted beat with in_last=1.
  - No transition without acceptance.
  - With PKT_MODE=0 the FSM stays in IDLE.
- Per-output buffer:
  - 2 entries, write pointer, read pointer, occupancy count 0..2.
  - An entry stores {last, data}.
  - Push on acceptance of a beat with esel=n.
  - Pop on outn_vld & outn_rdy.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - 1-bit pointers wrap 1→0.
- in_rdy = (count of buffer[esel] < 2). It depends only on registered state plus in_sel; it never depends on out*_rdy.
- outn_vld = (countn != 0). outn_data and outn_last are the head entry.
- A beat is written to exactly one buffer. The other buffer is never disturbed.
- The two outputs drain independently. Order is preserved within each output only.

## Timing
- Reset values:
  - All counts and pointers 0, FSM IDLE.
  - out0_vld = out1_vld = 0, out*_data = 0, out*_last = 0.
  - lock_state = 2'b00.
  - in_rdy = 1.
- Latency: a beat accepted in cycle N is presented on outn in cycle N+1.
- Throughput: 1 beat/cycle per output when that output's rdy is held high. A full buffer (count 2) drops in_rdy until a pop, which reopens it the next cycle.
- A full buffer blocks only beats destined for it. Beats for the other output flow in the same cycle, except in LOCK state, where the input stalls.
- Input stalls while in_vld=1 & in_rdy=0 must not change state. The upstream must hold in_data, in_sel and in_last; the block does not check this.
- outn_vld, once high, stays high with stable data until outn_rdy. This holds by construction.
- Reset asserted mid-packet:
  - Immediate return to IDLE.
  - Buffered beats discarded, outputs deasserted asynchronously.
  - Outputs stay deasserted until the first clock after release.

## Structure
- Shared package (`sa_demux_pkg`) holds:
  - FSM state constants SA_DMX_IDLE, SA_DMX_LOCK0, SA_DMX_LOCK1.
  - Buffer depth constant SA_DMX_DEPTH=2.
- One sub-module, `sa_skid_buf2`: parameterised WIDTH+1 2-entry buffer with push/pop/full/empty. Instantiated twice.
- FSM, esel and ready logic live in the top module.

## Test plan
- Per-beat routing: PKT_MODE=0, out rdys high, send data 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0) in consecutive cycles.
  - out0 shows 0x11 at cycle 1 and 0x33 at cycle 3.
  - out1 shows 0x22 at cycle 2.
  - in_rdy stays 1 throughout.
- Backpressure isolation: out0_rdy=0, push 3 beats to out0.
  - in_rdy drops after 2 beats.
  - A sel=1 beat is still accepted and appears on out1 next cycle.
  - Raising out0_rdy drains 2 beats in order and reopens in_rdy.
- Packet lock: PKT_MODE=1, 4-beat packet with in_sel = 1,0,0,1 and last on beat 4.
  - All 4 beats appear on out1.
  - lock_state goes 00→10 then back to 00 after beat 4.
- Single-beat packet: beat with last=1 and sel=0 in IDLE → delivered on out0, FSM stays IDLE.
- Simultaneous push/pop at count 1 on out1 → count stays 1, data order preserved, in_rdy=1.
- Reset mid-packet: assert nvdla_core_rstn low during LOCK0 with 2 buffered beats.
  - All out*_vld go 0 asynchronously.
  - lock_state=00 and in_rdy=1 after release.

Source files
------------

// File: rtl/sa_demux_pkg.sv
// sa_demux_pkg: shared constants, types and helpers for the two-way stream demultiplexer.
package sa_demux_pkg;

    typedef enum logic [1:0] {
        SA_DMX_IDLE  = 2'b00,
        SA_DMX_LOCK0 = 2'b01,
        SA_DMX_LOCK1 = 2'b10
    } sa_dmx_state_e;

    localparam int SA_DMX_DEPTH = 2;

    // Lock state that pins a packet to the output chosen by its first beat.
    function automatic sa_dmx_state_e sa_dmx_lock_of(input logic sel);
        return sel ? SA_DMX_LOCK1 : SA_DMX_LOCK0;
    endfunction

endpackage

// File: rtl/sa_skid_buf2.sv
// sa_skid_buf2: two-entry FIFO holding {last, data} for one demux output.
module sa_skid_buf2 import sa_demux_pkg::*; #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [SA_DMX_DEPTH];
    logic [WIDTH-1:0] mem_d [SA_DMX_DEPTH];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == 2'(SA_DMX_DEPTH);
    assign empty = cnt_q == 2'd0;
    assign head  = mem_q[rptr_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wptr_q] = push_data;
        wptr_d  = wptr_q ^ do_push;
        rptr_d  = rptr_q ^ do_pop;
        cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sa_demux2_pipe.sv
// sa_demux2_pipe: valid/ready demux steering each beat (or whole packet) to one of two
// buffered outputs; input ready never looks at downstream ready.
module sa_demux2_pipe import sa_demux_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int PKT_MODE = 1
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             out0_vld,
    input  logic             out0_rdy,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_vld,
    input  logic             out1_rdy,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic [1:0]       lock_state
);

    sa_dmx_state_e state_q, state_d;
    logic          esel, acc;
    logic [1:0]    push, pop, full, empty, out_rdy;
    logic [WIDTH:0] head [2];

    assign out_rdy = {out1_rdy, out0_rdy};

    always_comb begin
        esel    = (PKT_MODE == 0) ? in_sel :
                  (state_q == SA_DMX_LOCK0) ? 1'b0 :
                  (state_q == SA_DMX_LOCK1) ? 1'b1 : in_sel;
        in_rdy  = !full[esel];
        acc     = in_vld && in_rdy;
        push    = {acc && esel, acc && !esel};
        pop     = ~empty & out_rdy;
        state_d = state_q;
        if (PKT_MODE != 0 && acc)
            state_d = in_last ? SA_DMX_IDLE :
                      (state_q == SA_DMX_IDLE) ? sa_dmx_lock_of(esel) : state_q;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) state_q <= SA_DMX_IDLE;
        else                  state_q <= state_d;
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        sa_skid_buf2 #(.WIDTH(WIDTH + 1)) u_buf (
            .clk       (nvdla_core_clk),
            .rst_n     (nvdla_core_rstn),
            .push      (push[g]),
            .push_data ({in_last, in_data}),
            .pop       (pop[g]),
            .head      (head[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    assign out0_vld               = !empty[0];
    assign out1_vld               = !empty[1];
    assign {out0_last, out0_data} = head[0];
    assign {out1_last, out1_data} = head[1];
    assign lock_state             = state_q;

endmodule

// File: tb/tb_sa_demux2_pipe.sv
// tb_sa_demux2_pipe: scoreboard bench driving a per-beat (inst 0) and a packet-mode (inst 1)
// demux, predicting readiness, lock state and per-output beat order from a queue model.
module tb_sa_demux2_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         in_vld [2], in_sel [2], in_last [2], in_rdy [2];
    logic [W-1:0] in_data [2];
    logic         out_vld [2][2], out_rdy [2][2], out_last [2][2];
    logic [W-1:0] out_data [2][2];
    logic [1:0]   lock_state [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sa_demux2_pipe #(.WIDTH(W), .PKT_MODE(g)) u_dut (
            .nvdla_core_clk  (clk),
            .nvdla_core_rstn (rstn),
            .in_vld          (in_vld[g]),
            .in_rdy          (in_rdy[g]),
            .in_data         (in_data[g]),
            .in_sel          (in_sel[g]),
            .in_last         (in_last[g]),
            .out0_vld        (out_vld[g][0]),
            .out0_rdy        (out_rdy[g][0]),
            .out0_data       (out_data[g][0]),
            .out0_last       (out_last[g][0]),
            .out1_vld        (out_vld[g][1]),
            .out1_rdy        (out_rdy[g][1]),
            .out1_data       (out_data[g][1]),
            .out1_last       (out_last[g][1]),
            .lock_state      (lock_state[g])
        );
    end

    logic [W:0] sb [4][$];
    int         lk [2];
    bit         acc [2];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each output is a queue of at most 2 beats; packet lock is the owning output + 1.
    always @(negedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < 4; k++) sb[k].delete();
            lk  = '{0, 0};
            acc = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                int   es;
                logic er;
                es = (lk[i] != 0) ? lk[i] - 1 : int'(in_sel[i]);
                er = sb[2*i+es].size() < 2;
                chk($sformatf("in_rdy[%0d]", i), 64'(in_rdy[i]), 64'(er));
                chk($sformatf("lock_state[%0d]", i), 64'(lock_state[i]), 64'(lk[i]));
                for (int n = 0; n < 2; n++) begin
                    chk($sformatf("out%0d_vld[%0d]", n, i), 64'(out_vld[i][n]), 64'(sb[2*i+n].size() != 0));
                    if (out_vld[i][n] && sb[2*i+n].size() != 0) begin
                        chk($sformatf("out%0d_beat[%0d]", n, i), 64'({out_last[i][n], out_data[i][n]}),
                            64'(sb[2*i+n][0]));
                        if (out_rdy[i][n]) void'(sb[2*i+n].pop_front());
                    end
                end
                acc[i] = in_vld[i] && er;
                if (acc[i]) begin
                    sb[2*i+es].push_back({in_last[i], in_data[i]});
                    if (i == 1) lk[i] = in_last[i] ? 0 : (lk[i] == 0 ? es + 1 : lk[i]);
                end
            end
        end
    end

    task automatic send(input int i, input logic s, input logic l, input logic [W-1:0] d);
        int t = 0;
        in_vld[i] = 1'b1; in_sel[i] = s; in_last[i] = l; in_data[i] = d;
        do begin
            @(posedge clk);
            t++;
        end while (!acc[i] && t < 50);
        if (!acc[i]) chk("send_timeout", 64'(t), 64'(0));
        #1 in_vld[i] = 1'b0;
    endtask

    task automatic set_rdy(input int i, input logic r0, input logic r1);
        out_rdy[i][0] = r0;
        out_rdy[i][1] = r1;
    endtask

    task automatic drain();
        set_rdy(0, 1, 1);
        set_rdy(1, 1, 1);
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("drained[%0d]", k), 64'(sb[k].size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_vld[i] = 0; in_sel[i] = 0; in_last[i] = 0; in_data[i] = '0;
            set_rdy(i, 1, 1);
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_rdy", 64'(in_rdy[i]), 64'(1));
            chk("rst_lock", 64'(lock_state[i]), 64'(0));
            for (int n = 0; n < 2; n++) begin
                chk("rst_vld", 64'(out_vld[i][n]), 64'(0));
                chk("rst_data", 64'({out_last[i][n], out_data[i][n]}), 64'(0));
            end
        end
        #9 rstn = 1'b1;
        @(posedge clk); #1;

        send(0, 0, 0, 32'h11);
        send(0, 1, 0, 32'h22);
        send(0, 0, 0, 32'h33);
        drain();

        set_rdy(0, 0, 1);
        send(0, 0, 0, 32'h01);
        send(0, 0, 0, 32'h02);
        in_vld[0] = 1; in_sel[0] = 0; in_data[0] = 32'h03;
        repeat (3) @(posedge clk);
        chk("bp_blocked", 64'(acc[0]), 64'(0));
        #1 in_vld[0] = 0;
        send(0, 1, 0, 32'h44);
        out_rdy[0][0] = 1;
        send(0, 0, 0, 32'h03);
        drain();

        send(1, 1, 0, 32'hA1);
        chk("pkt_lock1", 64'(lock_state[1]), 64'(2));
        send(1, 0, 0, 32'hA2);
        send(1, 0, 0, 32'hA3);
        send(1, 1, 1, 32'hA4);
        chk("pkt_unlock", 64'(lock_state[1]), 64'(0));
        send(1, 0, 1, 32'hB1);
        chk("single_idle", 64'(lock_state[1]), 64'(0));
        drain();

        for (int k = 0; k < 4; k++) send(1, 1, 1, 32'hC0 + k);
        drain();

        set_rdy(1, 0, 0);
        send(1, 0, 0, 32'hD1);
        send(1, 0, 0, 32'hD2);
        @(negedge clk); #2 rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            for (int n = 0; n < 2; n++) chk("async_rst_vld", 64'(out_vld[i][n]), 64'(0));
        chk("async_rst_lock", 64'(lock_state[1]), 64'(0));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        chk("post_rst_rdy", 64'(in_rdy[1]), 64'(1));
        chk("post_rst_lock", 64'(lock_state[1]), 64'(0));
        set_rdy(1, 1, 1);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                out_rdy[i][0] = $urandom_range(0, 3) != 0;
                out_rdy[i][1] = $urandom_range(0, 2) != 0;
                if (!in_vld[i] || acc[i]) begin
                    in_vld[i]  = $urandom_range(0, 9) < 7;
                    in_sel[i]  = 1'($urandom_range(0, 1));
                    in_last[i] = $urandom_range(0, 3) == 0;
                    in_data[i] = $urandom;
                end
            end
        end
        in_vld[0] = 0;
        in_vld[1] = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
